// File: rtl/inst_sequencer_if.sv
// Instruction- and data-memory req/ack handshake bundle between the sequencer (master)
// and its memories (slave).
interface inst_sequencer_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_addr, imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/inst_sequencer.sv
// Multi-cycle control FSM for the 16-bit core: fetch, decode and EXEC/MEM/WB sequencing,
// PC ownership, memory handshakes, register-file write strobe and illegal-opcode/timeout trap.
module inst_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  inst_sequencer_if.master mem,
  output logic [15:0]      ir,
  input  logic             alu_zero,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [15:0]      link_pc,
  output logic             trap,
  output logic [15:0]      retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_NDU = 4'h2;
  localparam logic [3:0] OP_LW  = 4'h4;
  localparam logic [3:0] OP_SW  = 4'h5;
  localparam logic [3:0] OP_JAL = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'hC;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [15:0] wait_cnt;
  logic        complete;
  logic        timed_out;
  logic        legal_op;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [3:0]  opcode;
  logic [15:0] offset;

  assign opcode    = ir[15:12];
  assign offset    = {{10{ir[5]}}, ir[5:0]};
  assign legal_op  = opcode inside {OP_ADD, OP_NDU, OP_LW, OP_SW, OP_JAL, OP_BEQ};
  assign timed_out = (TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST);

  assign link_pc       = pc + 16'd1;
  assign state         = cur_state;
  assign mem.imem_addr = pc;
  assign mem.imem_req  = imem_req_q;
  assign mem.dmem_req  = dmem_req_q;
  assign mem.dmem_we   = dmem_we_q;

  // Completion of any instruction funnels through one point so retire and the run check stay in one place.
  always_comb begin
    nxt_state = cur_state;
    pc_nxt    = pc;
    complete  = 1'b0;
    case (cur_state)
      S_IDLE:   if (run) nxt_state = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ack)   nxt_state = S_DECODE;
        else if (timed_out) nxt_state = S_TRAP;
      end
      S_DECODE: nxt_state = legal_op ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEM;
          OP_BEQ: begin
            complete = 1'b1;
            pc_nxt   = alu_zero ? pc + offset : pc + 16'd1;
          end
          default: nxt_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (opcode == OP_SW) begin
            complete = 1'b1;
            pc_nxt   = pc + 16'd1;
          end else begin
            nxt_state = S_WB;
          end
        end else if (timed_out) begin
          nxt_state = S_TRAP;
        end
      end
      S_WB: begin
        complete = 1'b1;
        pc_nxt   = (opcode == OP_JAL) ? pc + offset : pc + 16'd1;
      end
      default: nxt_state = S_TRAP;
    endcase
    if (complete) nxt_state = run ? S_FETCH : S_IDLE;
  end

  // Strobes are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      retired    <= '0;
      trap       <= 1'b0;
      wait_cnt   <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we      <= 1'b0;
      wb_sel     <= 2'b00;
    end else begin
      cur_state <= nxt_state;
      pc        <= pc_nxt;
      if (cur_state == S_FETCH && mem.imem_ack) ir <= mem.imem_rdata;
      if (complete) retired <= retired + 16'd1;
      if (nxt_state == S_TRAP) trap <= 1'b1;
      if ((cur_state == S_FETCH && !mem.imem_ack) || (cur_state == S_MEM && !mem.dmem_ack))
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
      imem_req_q <= (nxt_state == S_FETCH);
      dmem_req_q <= (nxt_state == S_MEM);
      dmem_we_q  <= (nxt_state == S_MEM) && (opcode == OP_SW);
      rf_we      <= (nxt_state == S_WB);
      if (nxt_state != S_WB)     wb_sel <= 2'b00;
      else if (opcode == OP_LW)  wb_sel <= 2'b01;
      else if (opcode == OP_JAL) wb_sel <= 2'b10;
      else                       wb_sel <= 2'b00;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
`timescale 1ns/1ps
// Bench for inst_sequencer: directed vector table, multi-cycle corner sequences and a
// randomized instruction stream checked against an instruction-level reference model.
module tb_inst_sequencer;

  typedef struct {
    logic [15:0] pc;
    int          cyc;
    int          rf;
    int          dreq;
    logic [1:0]  wb;
    logic [15:0] link;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic        az;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        alu_zero;
  logic [15:0] ir;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [15:0] link_pc;
  logic        trap;
  logic [15:0] retired;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int ret_model;

  inst_sequencer_if bus();

  inst_sequencer #(.RESET_PC(16'h0000), .TIMEOUT_CYC(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .mem      (bus),
    .ir       (ir),
    .alu_zero (alu_zero),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .link_pc  (link_pc),
    .trap     (trap),
    .retired  (retired),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyReset();
    rst_n          = 1'b0;
    run            = 1'b0;
    alu_zero       = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    ret_model = 0;
    @(negedge clk);
  endtask

  // Runs one instruction from the current negedge until retired moves, acting as both memories.
  task automatic applyStimulus(input logic [15:0] instr, input logic az, input int iw, input int dw,
                               input bit drop_run, output int cycles, output int rf_pulses,
                               output int rf_cyc, output logic [1:0] wb_seen, output logic [15:0] link_seen,
                               output int dreq_cycles, output int bad, output bit timed_out);
    logic [15:0] start_ret;
    int          fwait, dwait, iter;
    bit          started;
    start_ret = retired;
    cycles = 0; rf_pulses = 0; rf_cyc = 0; wb_seen = 2'b11; link_seen = 16'h0000;
    dreq_cycles = 0; bad = 0; timed_out = 1'b0;
    fwait = 0; dwait = 0; iter = 0; started = 1'b0;
    alu_zero = az;
    while (retired == start_ret) begin
      if (iter++ > 60) begin
        timed_out = 1'b1;
        break;
      end
      if (bus.imem_req) started = 1'b1;
      if (started) cycles++;
      if (bus.imem_req && bus.dmem_req) bad++;
      if (rf_we) begin
        rf_pulses++;
        rf_cyc    = cycles;
        wb_seen   = wb_sel;
        link_seen = link_pc;
      end
      if (bus.dmem_req) begin
        dreq_cycles++;
        if (bus.dmem_we !== (instr[15:12] == 4'h5)) bad++;
      end
      bus.imem_ack   = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.imem_rdata = 16'h0000;
      if (bus.imem_req) begin
        if (fwait == iw) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = instr;
          if (drop_run) run = 1'b0;
        end
        fwait++;
      end
      if (bus.dmem_req) begin
        if (dwait == dw) bus.dmem_ack = 1'b1;
        dwait++;
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic runExpect(input string name, input logic [15:0] instr, input logic az,
                           input int iw, input int dw, input exp_t e);
    int          cyc, rfp, rfc, dreq, bad;
    logic [1:0]  wbs;
    logic [15:0] lnk;
    bit          to;
    run = 1'b1;
    applyStimulus(instr, az, iw, dw, 1'b0, cyc, rfp, rfc, wbs, lnk, dreq, bad, to);
    ret_model++;
    checkOutput($sformatf("%s completes", name), 32'(to), 32'd0);
    checkOutput($sformatf("%s pc", name), 32'(bus.imem_addr), 32'(e.pc));
    checkOutput($sformatf("%s cycles", name), cyc, e.cyc);
    checkOutput($sformatf("%s rf_we pulses", name), rfp, e.rf);
    checkOutput($sformatf("%s dmem_req cycles", name), dreq, e.dreq);
    checkOutput($sformatf("%s protocol", name), bad, 0);
    checkOutput($sformatf("%s retired", name), 32'(retired), 32'(ret_model[15:0]));
    checkOutput($sformatf("%s ir", name), 32'(ir), 32'(instr));
    checkOutput($sformatf("%s trap", name), 32'(trap), 32'd0);
    if (e.rf != 0) begin
      checkOutput($sformatf("%s rf_we in last cycle", name), rfc, e.cyc);
      checkOutput($sformatf("%s wb_sel", name), 32'(wbs), 32'(e.wb));
      checkOutput($sformatf("%s link_pc", name), 32'(lnk), 32'(e.link));
    end
  endtask

  // Instruction-level model: architectural effect plus phase-count latency.
  function automatic exp_t refModel(input logic [15:0] instr, input logic az, input logic [15:0] pc,
                                    input int iw, input int dw);
    exp_t r;
    int   off;
    int   p;
    off = int'(instr[5:0]);
    if (off > 31) off -= 64;
    p      = int'(pc);
    r.pc   = 16'((p + 1) & 32'hFFFF);
    r.cyc  = 4 + iw;
    r.rf   = 1;
    r.dreq = 0;
    r.wb   = 2'b00;
    r.link = 16'((p + 1) & 32'hFFFF);
    case (instr[15:12])
      4'h4: begin r.cyc = 5 + iw + dw; r.dreq = 1 + dw; r.wb = 2'b01; end
      4'h5: begin r.cyc = 4 + iw + dw; r.dreq = 1 + dw; r.rf = 0; end
      4'h8: begin r.wb = 2'b10; r.pc = 16'((p + off) & 32'hFFFF); end
      4'hC: begin
        r.cyc = 3 + iw;
        r.rf  = 0;
        if (az) r.pc = 16'((p + off) & 32'hFFFF);
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  vec_t        vecs[12];
  logic [3:0]  ops[6] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h8, 4'hC};
  exp_t        e;
  logic [15:0] pc_m;
  logic [15:0] instr;
  logic        az;
  int          iw, dw, reqs;
  int          cyc, rfp, rfc, dreq, bad;
  logic [1:0]  wbs;
  logic [15:0] lnk;
  bit          to;

  initial begin
    vecs[0]  = '{16'h0298, 1'b0, '{16'h0001, 4, 1, 0, 2'b00, 16'h0001}};
    vecs[1]  = '{16'h4283, 1'b0, '{16'h0002, 5, 1, 1, 2'b01, 16'h0002}};
    vecs[2]  = '{16'h5283, 1'b0, '{16'h0003, 4, 0, 1, 2'b00, 16'h0000}};
    vecs[3]  = '{16'h2001, 1'b0, '{16'h0004, 4, 1, 0, 2'b00, 16'h0004}};
    vecs[4]  = '{16'h800C, 1'b0, '{16'h0010, 4, 1, 0, 2'b10, 16'h0005}};
    vecs[5]  = '{16'hC07E, 1'b1, '{16'h000E, 3, 0, 0, 2'b00, 16'h0000}};
    vecs[6]  = '{16'h8002, 1'b0, '{16'h0010, 4, 1, 0, 2'b10, 16'h000F}};
    vecs[7]  = '{16'hC07E, 1'b0, '{16'h0011, 3, 0, 0, 2'b00, 16'h0000}};
    vecs[8]  = '{16'h800F, 1'b0, '{16'h0020, 4, 1, 0, 2'b10, 16'h0012}};
    vecs[9]  = '{16'h8005, 1'b0, '{16'h0025, 4, 1, 0, 2'b10, 16'h0021}};
    vecs[10] = '{16'hC020, 1'b1, '{16'h0005, 3, 0, 0, 2'b00, 16'h0000}};
    vecs[11] = '{16'hC01F, 1'b1, '{16'h0024, 3, 0, 0, 2'b00, 16'h0000}};

    applyReset();
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset pc", 32'(bus.imem_addr), 32'h0000);
    checkOutput("reset ir", 32'(ir), 32'h0000);
    checkOutput("reset retired", 32'(retired), 32'h0000);
    checkOutput("reset trap", 32'(trap), 32'd0);
    checkOutput("reset imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset dmem_req", 32'(bus.dmem_req), 32'd0);
    checkOutput("reset dmem_we", 32'(bus.dmem_we), 32'd0);
    checkOutput("reset rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset wb_sel", 32'(wb_sel), 32'd0);

    for (int i = 0; i < 12; i++)
      runExpect($sformatf("vec%0d", i), vecs[i].instr, vecs[i].az, 0, 0, vecs[i].exp);

    // LW whose data ack arrives on the third request cycle.
    applyReset();
    runExpect("lw_wait", 16'h4283, 1'b0, 0, 2, '{16'h0001, 7, 1, 3, 2'b01, 16'h0001});

    // Branch to FFFF, then a JAL there wraps both link and target.
    applyReset();
    runExpect("beq_to_ffff", 16'hC03F, 1'b1, 0, 0, '{16'hFFFF, 3, 0, 0, 2'b00, 16'h0000});
    runExpect("jal_wrap", 16'h8001, 1'b0, 0, 0, '{16'h0000, 4, 1, 0, 2'b10, 16'h0000});

    // run dropped during an ADD: it still retires, then the FSM parks.
    applyReset();
    run = 1'b1;
    applyStimulus(16'h0298, 1'b0, 0, 0, 1'b1, cyc, rfp, rfc, wbs, lnk, dreq, bad, to);
    checkOutput("run_drop cycles", cyc, 4);
    checkOutput("run_drop rf_we pulses", rfp, 1);
    checkOutput("run_drop state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("run_drop idle state", 32'(state), 32'd0);
    checkOutput("run_drop no fetch", 32'(bus.imem_req), 32'd0);
    checkOutput("run_drop retired", 32'(retired), 32'd1);
    checkOutput("run_drop pc", 32'(bus.imem_addr), 32'h0001);

    // Asynchronous reset while a load waits in MEM.
    applyReset();
    run = 1'b1;
    for (int i = 0; i < 20 && !bus.dmem_req; i++) begin
      bus.imem_ack   = bus.imem_req;
      bus.imem_rdata = 16'h4283;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    checkOutput("mid_mem dmem_req up", 32'(bus.dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_mem reset dmem_req", 32'(bus.dmem_req), 32'd0);
    checkOutput("mid_mem reset state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal opcode traps and stays quiet until reset.
    applyReset();
    run = 1'b1;
    for (int i = 0; i < 10 && !bus.imem_req; i++) @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hF000;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    checkOutput("illegal state", 32'(state), 32'd7);
    checkOutput("illegal trap", 32'(trap), 32'd1);
    reqs = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_req || rf_we) reqs++;
    end
    checkOutput("illegal quiet cycles", reqs, 0);
    checkOutput("illegal pc frozen", 32'(bus.imem_addr), 32'h0000);
    checkOutput("illegal ir held", 32'(ir), 32'hF000);
    checkOutput("illegal trap sticky", 32'(trap), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("illegal reset trap", 32'(trap), 32'd0);
    checkOutput("illegal reset pc", 32'(bus.imem_addr), 32'h0000);
    checkOutput("illegal reset state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch never acknowledged: request held for TIMEOUT_CYC cycles, then TRAP.
    applyReset();
    run  = 1'b1;
    reqs = 0;
    for (int i = 0; i < 40 && state != 3'd7; i++) begin
      @(negedge clk);
      if (bus.imem_req) reqs++;
    end
    checkOutput("timeout req cycles", reqs, 8);
    checkOutput("timeout state", 32'(state), 32'd7);
    checkOutput("timeout trap", 32'(trap), 32'd1);
    checkOutput("timeout req dropped", 32'(bus.imem_req), 32'd0);

    // Random legal instruction stream with random memory wait states.
    applyReset();
    pc_m = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      instr = {ops[$urandom_range(0, 5)], 12'($urandom)};
      az    = 1'($urandom);
      iw    = $urandom_range(0, 4);
      dw    = $urandom_range(0, 4);
      e     = refModel(instr, az, pc_m, iw, dw);
      runExpect($sformatf("rand%0d op%0h", i, instr[15:12]), instr, az, iw, dw, e);
      pc_m = e.pc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
